bsg_reorder_fifo: RTL and testbench
===================================

// Module: bsg_reorder_fifo
// PURPOSE
// - Completion-reorder buffer for split transactions (e.g. manycore MMIO loads/stores).
// - Requester allocates sequential IDs; responses are written by ID in any order.
// - Data is dequeued strictly in allocation order.
// - Sits between a request issuer and its out-of-order response network.
// PARAMETERS
// - width_p  none(required)  payload width in bits
// - els_p    32              number of IDs/entries; >=2, need not be a power of 2
// - id width: lg_els = max(1, clog2(els_p))
// PORTS
// - clk_i              in   1        clock, rising edge
// - reset_n_i          in   1        synchronous reset, active-low
// - fifo_alloc_id_o    out  lg_els   ID granted to the next allocation
// - fifo_alloc_v_o     out  1        an ID is available (buffer not full)
// - fifo_alloc_yumi_i  in   1        consume fifo_alloc_id_o; legal only when fifo_alloc_v_o=1
// - write_id_i         in   lg_els   ID of the returning response
// - write_data_i       in   width_p  response data
// - write_v_i          in   1        write strobe; always accepted, no backpressure
// - fifo_deq_data_o    out  width_p  data of the oldest allocated entry
// - fifo_deq_v_o       out  1        oldest entry has been written
// - fifo_deq_yumi_i    in   1        consume the head; legal only when fifo_deq_v_o=1
// - empty_o            out  1        no IDs outstanding
// BEHAVIOUR
// - State:
//   - alloc ptr wp, deq ptr rp: mod-els_p counters.
//   - Occupancy count cnt: 0..els_p.
//   - Per-entry valid bit vld[els_p]; data RAM mem[els_p] (1 write port, async read).
// - Reset (reset_n_i=0 at posedge):
//   - wp=rp=cnt=0, vld=0; mem is not reset.
//   - Outputs then read: alloc_v=1, alloc_id=0, deq_v=0, empty=1.
// - Allocation:
//   - fifo_alloc_v_o = (cnt != els_p); fifo_alloc_id_o = wp.
//   - Both depend only on registers, with no combinational path from any input.
//   - yumi: wp <= wp+1, wrapping els_p-1 -> 0.
// - Write:
//   - write_v_i: mem[write_id_i] <= write_data_i; vld[write_id_i] <= 1.
//   - Visible on fifo_deq_* the next cycle.
// - Dequeue:
//   - fifo_deq_v_o = vld[rp]; fifo_deq_data_o = mem[rp] (combinational).
//   - yumi: vld[rp] <= 0; rp <= rp+1 with wrap.
// - Occupancy:
//   - cnt <= cnt + alloc_yumi - deq_yumi.
//   - Simultaneous alloc and deq leaves cnt unchanged.
//   - empty_o = (cnt == 0).
// - Full: alloc_v=0 until a dequeue. Dequeue and alloc in the same cycle while full is impossible (alloc_v=0).
// - Empty: deq_v=0 regardless of stale vld bits. vld is cleared on deq, so the invariant holds.
// - Simultaneous events:
//   - A write to ID x and a dequeue of a different ID in one cycle are both performed.
//   - alloc + write + deq in one cycle are all independent.
// - Illegal, flagged by assertions and ignored by the datapath contract:
//   - alloc_yumi while !alloc_v; deq_yumi while !deq_v.
//   - write to an unallocated ID, or to an already-valid ID.
//   - write to an ID in the same cycle it is allocated.
// - Reset mid-operation discards all outstanding IDs and data; late writes after reset are illegal.
// CONFIGURATION
// - BSG_REORDER_FIFO_BYPASS_EN defined:
//   - If write_v_i && write_id_i==rp && cnt!=0: fifo_deq_v_o=1 and fifo_deq_data_o=write_data_i in the same cycle.
//   - Dequeue in that cycle leaves vld[rp]=0 afterwards.
//   - The RAM is still written.
// - Not defined:
//   - Write-to-dequeue latency is exactly 1 cycle.
//   - No combinational path from write_* to fifo_deq_*.
// TESTING
// - Reset, then check idle outputs -> alloc_v=1, alloc_id=0, deq_v=0, empty=1.
// - In-order flow: alloc IDs 0,1,2; write 0:0xA,1:0xB,2:0xC -> dequeue 0xA,0xB,0xC; empty=1 after the third.
// - Out-of-order writes:
//   - els_p=4; alloc 0..3; alloc_v=0 when full.
//   - Write 3:0xD, 1:0xB, 2:0xC -> deq_v stays 0.
//   - Write 0:0xA -> next cycle 0xA,0xB,0xC,0xD dequeue on consecutive cycles.
// - Wrap-around:
//   - els_p=4; 10 alloc/write/deq rounds keeping 3 outstanding -> IDs go 0,1,2,3,0,...
//   - Data returns in order; alloc_v never drops while cnt<4.
// - Simultaneous events:
//   - Full buffer, head valid; same cycle deq_yumi, plus write to ID rp+1 -> cnt=3, alloc_v=1 next cycle.
//   - The written data dequeues next.
// - Bypass:
//   - With BYPASS_EN, write head ID 0x55 -> deq_v=1, data 0x55 in the same cycle.
//   - Without BYPASS_EN, same stimulus -> deq_v=1 one cycle later.

Source files
------------

// File: rtl/bsg_reorder_fifo_if.sv
// ============================================================================
// Module      : bsg_reorder_fifo_if
// Description : Allocation, response-write and dequeue signals of the
//               completion-reorder buffer; slave = buffer, master = requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bsg_reorder_fifo_if #(
    parameter int WIDTH_P = 8,
    parameter int ELS_P   = 32
);
    localparam int LG_ELS = (ELS_P > 2) ? $clog2(ELS_P) : 1;

    logic [LG_ELS-1:0]  fifo_alloc_id_o;
    logic               fifo_alloc_v_o;
    logic               fifo_alloc_yumi_i;
    logic [LG_ELS-1:0]  write_id_i;
    logic [WIDTH_P-1:0] write_data_i;
    logic               write_v_i;
    logic [WIDTH_P-1:0] fifo_deq_data_o;
    logic               fifo_deq_v_o;
    logic               fifo_deq_yumi_i;
    logic               empty_o;

    modport slave (
        output fifo_alloc_id_o,
        output fifo_alloc_v_o,
        input  fifo_alloc_yumi_i,
        input  write_id_i,
        input  write_data_i,
        input  write_v_i,
        output fifo_deq_data_o,
        output fifo_deq_v_o,
        input  fifo_deq_yumi_i,
        output empty_o
    );

    modport master (
        input  fifo_alloc_id_o,
        input  fifo_alloc_v_o,
        output fifo_alloc_yumi_i,
        output write_id_i,
        output write_data_i,
        output write_v_i,
        input  fifo_deq_data_o,
        input  fifo_deq_v_o,
        output fifo_deq_yumi_i,
        input  empty_o
    );
endinterface

`default_nettype wire

// File: rtl/bsg_reorder_fifo.sv
// ============================================================================
// Module      : bsg_reorder_fifo
// Description : Completion-reorder buffer: sequential ID allocation, writes by
//               ID in any order, dequeue in allocation order. Optional
//               same-cycle write-to-head bypass via BSG_REORDER_FIFO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_reorder_fifo #(
    parameter int WIDTH_P = 8,
    parameter int ELS_P   = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bsg_reorder_fifo_if.slave   io
);

    localparam int                LG_ELS   = (ELS_P > 2) ? $clog2(ELS_P) : 1;
    localparam int                CNT_W    = $clog2(ELS_P + 1);
    localparam logic [LG_ELS-1:0] LAST_ID  = LG_ELS'(ELS_P - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ELS_P);
    localparam logic [LG_ELS:0]   ID_LIMIT = (LG_ELS + 1)'(ELS_P);

    function automatic logic [LG_ELS-1:0] next_ptr(input logic [LG_ELS-1:0] p);
        return (p == LAST_ID) ? '0 : p + LG_ELS'(1);
    endfunction

    logic [LG_ELS-1:0]  wp_q, wp_d;
    logic [LG_ELS-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ELS_P-1:0]   vld_q, vld_d;
    logic [WIDTH_P-1:0] mem_q [ELS_P];

    logic w_alloc_v;
    logic w_empty;
    logic w_head_vld;
    logic w_deq_v;
    logic w_alloc;
    logic w_deq;
    logic w_write_en;

    assign w_alloc_v  = (cnt_q != FULL_CNT);
    assign w_empty    = (cnt_q == '0);
    assign w_head_vld = vld_q[rp_q] && !w_empty;

    // Out-of-range IDs (non-power-of-two depth) never touch state.
    assign w_write_en = io.write_v_i && ({1'b0, io.write_id_i} < ID_LIMIT);

`ifdef BSG_REORDER_FIFO_BYPASS_EN
    logic w_bypass;
    assign w_bypass           = io.write_v_i && (io.write_id_i == rp_q) && !w_empty;
    assign w_deq_v            = w_head_vld || w_bypass;
    assign io.fifo_deq_data_o = w_bypass ? io.write_data_i : mem_q[rp_q];
`else
    assign w_deq_v            = w_head_vld;
    assign io.fifo_deq_data_o = mem_q[rp_q];
`endif

    // Illegal handshakes are masked so they cannot corrupt pointers.
    assign w_alloc = io.fifo_alloc_yumi_i && w_alloc_v;
    assign w_deq   = io.fifo_deq_yumi_i && w_deq_v;

    assign io.fifo_alloc_id_o = wp_q;
    assign io.fifo_alloc_v_o  = w_alloc_v;
    assign io.fifo_deq_v_o    = w_deq_v;
    assign io.empty_o         = w_empty;

    always_comb begin
        wp_d  = w_alloc ? next_ptr(wp_q) : wp_q;
        rp_d  = w_deq ? next_ptr(rp_q) : rp_q;
        cnt_d = cnt_q;
        case ({w_alloc, w_deq})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        vld_d = vld_q;
        if (w_write_en) begin
            vld_d[io.write_id_i] = 1'b1;
        end
        // Clear after set: a bypassed write consumed in the same cycle leaves no stale valid.
        if (w_deq) begin
            vld_d[rp_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_write_en) begin
            mem_q[io.write_id_i] <= io.write_data_i;
        end
    end

`ifndef SYNTHESIS
    logic [LG_ELS:0] w_write_offset;

    // Distance of the written ID from the head, modulo the ring size.
    always_comb begin
        w_write_offset = '0;
        if (io.write_id_i >= rp_q) begin
            w_write_offset = {1'b0, io.write_id_i} - {1'b0, rp_q};
        end else begin
            w_write_offset = {1'b0, io.write_id_i} + ID_LIMIT - {1'b0, rp_q};
        end
    end

    a_alloc_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io.fifo_alloc_yumi_i |-> w_alloc_v);

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io.fifo_deq_yumi_i |-> w_deq_v);

    a_write_outstanding: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io.write_v_i |-> (w_write_en && (int'(w_write_offset) < int'(cnt_q))));

    a_write_not_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        w_write_en |-> !vld_q[io.write_id_i]);

    a_write_not_allocating: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (io.write_v_i && io.fifo_alloc_yumi_i) |-> (io.write_id_i != wp_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_reorder_fifo.sv
// ============================================================================
// Module      : tb_bsg_reorder_fifo
// Description : Self-checking bench for bsg_reorder_fifo (depth 4) against a
//               queue-based model of outstanding IDs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_reorder_fifo;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int LG = 2;
`ifdef BSG_REORDER_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_reorder_fifo_if #(.WIDTH_P(W), .ELS_P(N)) fif ();

    bsg_reorder_fifo #(.WIDTH_P(W), .ELS_P(N)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (fif)
    );

    // Model: IDs in allocation order, plus per-ID written flag and data.
    int         q_ids[$];
    bit         written_m[N];
    logic [W-1:0] data_m[N];
    int         next_id;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_ids.delete();
        for (int i = 0; i < N; i++) written_m[i] = 1'b0;
        next_id = 0;
    endtask

    task automatic step(input bit a, input bit wv, input int wid, input logic [W-1:0] wd, input bit d);
        bit           exp_dv;
        logic [W-1:0] exp_dd;
        int           head;
        fif.fifo_alloc_yumi_i = a;
        fif.write_v_i         = wv;
        fif.write_id_i        = LG'(wid);
        fif.write_data_i      = wd;
        fif.fifo_deq_yumi_i   = d;
        #1;
        head   = (q_ids.size() > 0) ? q_ids[0] : -1;
        exp_dv = 1'b0;
        exp_dd = '0;
        if (head >= 0 && written_m[head]) begin
            exp_dv = 1'b1;
            exp_dd = data_m[head];
        end
        if (BYPASS && head >= 0 && wv && wid == head) begin
            exp_dv = 1'b1;
            exp_dd = wd;
        end
        check_value("alloc_v", 32'(fif.fifo_alloc_v_o), 32'(q_ids.size() < N));
        check_value("alloc_id", 32'(fif.fifo_alloc_id_o), 32'(next_id));
        check_value("empty", 32'(fif.empty_o), 32'(q_ids.size() == 0));
        check_value("deq_v", 32'(fif.fifo_deq_v_o), 32'(exp_dv));
        if (exp_dv) check_value("deq_data", 32'(fif.fifo_deq_data_o), 32'(exp_dd));
        @(posedge clk);
        if (wv) begin
            written_m[wid] = 1'b1;
            data_m[wid]    = wd;
        end
        if (d) begin
            written_m[q_ids[0]] = 1'b0;
            head = q_ids.pop_front();
        end
        if (a) begin
            q_ids.push_back(next_id);
            next_id = (next_id + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset();
        fif.fifo_alloc_yumi_i = 1'b0;
        fif.write_v_i         = 1'b0;
        fif.fifo_deq_yumi_i   = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic random_phase(input int cycles);
        int           cand[$];
        bit           a, wv, d;
        int           wid, head;
        logic [W-1:0] wd;
        for (int c = 0; c < cycles; c++) begin
            cand.delete();
            foreach (q_ids[k]) if (!written_m[q_ids[k]]) cand.push_back(q_ids[k]);
            a   = (q_ids.size() < N) && ($urandom % 2 == 1);
            wv  = (cand.size() > 0) && ($urandom % 3 != 0);
            wid = wv ? cand[$urandom_range(0, cand.size() - 1)] : 0;
            wd  = W'($urandom);
            head = (q_ids.size() > 0) ? q_ids[0] : -1;
            d   = (head >= 0) && (written_m[head] || (BYPASS && wv && wid == head))
                  && ($urandom % 2 == 1);
            step(a, wv, wid, wd, d);
        end
    endtask

    initial begin
        fif.fifo_alloc_yumi_i = 1'b0;
        fif.write_v_i         = 1'b0;
        fif.write_id_i        = '0;
        fif.write_data_i      = '0;
        fif.fifo_deq_yumi_i   = 1'b0;
        model_clear();
        do_reset();
        step(0, 0, 0, 8'h00, 0);

        // In-order flow
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'h0A, 0);
        step(0, 1, 1, 8'h0B, 0);
        step(0, 1, 2, 8'h0C, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Out-of-order completion into a full buffer
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 3, 8'h0D, 0);
        step(0, 1, 1, 8'h0B, 0);
        step(0, 1, 2, 8'h0C, 0);
        step(0, 1, 0, 8'h0A, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Full, head valid: dequeue and write the next ID together
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'h11, 0);
        step(0, 1, 1, 8'h22, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 1, 2, 8'h33, 0);
        step(0, 1, 3, 8'h44, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Write to the head: same-cycle visibility only with bypass
        do_reset();
        step(1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 8'h55, 0);
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'h66, BYPASS);
        step(0, 0, 0, 8'h00, 0);
        if (!BYPASS) step(0, 0, 0, 8'h00, 1);

        // Wrap-around with three outstanding
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, i, W'(8'hA0 + i), 0);
        for (int r = 0; r < 10; r++) begin
            step(1, 0, 0, 8'h00, 1);
            step(0, 1, q_ids[$], W'(8'hB0 + r), 0);
        end

        random_phase(300);
        do_reset();
        step(0, 0, 0, 8'h00, 0);
        random_phase(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
